minmax_tracker: RTL and testbench

MINMAX_TRACKER -- requirements
Module: minmax_tracker

---
 rtl/minmax_tracker.sv | 122 ++++++++++++
 tb/tb_minmax_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/minmax_tracker.sv
// Windowed min/max tracker: captures the extremes and sample count over a window of len samples.
// Optional MINMAX_TRACKER_INDEX_EN adds min_idx/max_idx (0-based first-occurrence positions).
module minmax_tracker #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             signed_cmp,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
    output logic [7:0]       count,
    output logic             busy
`ifdef MINMAX_TRACKER_INDEX_EN
    ,
    output logic [7:0]       min_idx,
    output logic [7:0]       max_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] len_q;
    logic       signed_q;
    logic       accept;
    logic       start_ok;
    logic       first;
    logic       new_min;
    logic       new_max;

    // Signed order: differing sign bits decide directly, otherwise unsigned order holds.
    function automatic logic less_than(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             sgn);
        if (sgn && (a[WIDTH-1] != b[WIDTH-1]))
            return a[WIDTH-1];
        return a < b;
    endfunction

    assign start_ok = (state == IDLE) && start && (len != 8'd0);
    assign accept   = in_valid && in_ready;
    assign first    = (count == 8'd0);
    assign new_min  = first || less_than(in_data, min_val, signed_q);
    assign new_max  = first || less_than(max_val, in_data, signed_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != 8'd0))
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && ((count + 8'd1) == len_q))
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            signed_q <= 1'b0;
            count    <= '0;
            min_val  <= '0;
            max_val  <= '0;
`ifdef MINMAX_TRACKER_INDEX_EN
            min_idx  <= '0;
            max_idx  <= '0;
`endif
        end else if (start_ok) begin
            len_q    <= len;
            signed_q <= signed_cmp;
            count    <= '0;
        end else if (accept) begin
            count <= count + 8'd1;
            if (new_min) begin
                min_val <= in_data;
`ifdef MINMAX_TRACKER_INDEX_EN
                min_idx <= count;
`endif
            end
            if (new_max) begin
                max_val <= in_data;
`ifdef MINMAX_TRACKER_INDEX_EN
                max_idx <= count;
`endif
            end
        end
    end

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker: directed cases plus randomized windows against a queue model.
module tb_minmax_tracker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   len = '0;
    logic         signed_cmp = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] min_val;
    logic [W-1:0] max_val;
    logic [7:0]   count;
    logic         busy;
`ifdef MINMAX_TRACKER_INDEX_EN
    logic [7:0]   min_idx;
    logic [7:0]   max_idx;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] samp[$];
    logic [W-1:0] exp_min, exp_max;
    int           exp_min_i, exp_max_i;

    minmax_tracker #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .signed_cmp(signed_cmp),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .min_val(min_val), .max_val(max_val), .count(count), .busy(busy)
`ifdef MINMAX_TRACKER_INDEX_EN
        , .min_idx(min_idx), .max_idx(max_idx)
`endif
    );

    always #5 clk = ~clk;

    // Extremes by numeric value; strict comparisons keep the first occurrence.
    function automatic void model(input bit sgn);
        int k, kmin, kmax;
        kmin = 0;
        kmax = 0;
        foreach (samp[i]) begin
            k = sgn ? int'($signed(samp[i])) : int'(samp[i]);
            if (i == 0 || k < kmin) begin kmin = k; exp_min = samp[i]; exp_min_i = i; end
            if (i == 0 || k > kmax) begin kmax = k; exp_max = samp[i]; exp_max_i = i; end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_window(input logic [7:0] l, input bit s);
        @(negedge clk);
        start = 1'b1; len = l; signed_cmp = s;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        chk("count_cleared", count, 0);
    endtask

    task automatic feed(input int gaps_max, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gaps_max, 0)) begin
                in_data = W'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = samp[i];
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_done(input bit sgn, input int hold);
        int t;
        model(sgn);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid", out_valid, 1);
        chk("min_val", min_val, exp_min);
        chk("max_val", max_val, exp_max);
        chk("count", count, samp.size());
        chk("in_ready_done", in_ready, 0);
        chk("busy_done", busy, 1);
`ifdef MINMAX_TRACKER_INDEX_EN
        chk("min_idx", min_idx, exp_min_i);
        chk("max_idx", max_idx, exp_max_i);
`endif
        for (int c = 0; c < hold; c++) begin
            start    = 1'b1;
            len      = 8'd5;
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_min", min_val, exp_min);
            chk("hold_max", max_val, exp_max);
            chk("hold_count", count, samp.size());
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_min_held", min_val, exp_min);
        chk("idle_max_held", max_val, exp_max);
        chk("idle_count_held", count, samp.size());
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_min"}, min_val, 0);
        chk({tag, "_max"}, max_val, 0);
        chk({tag, "_count"}, count, 0);
`ifdef MINMAX_TRACKER_INDEX_EN
        chk({tag, "_min_idx"}, min_idx, 0);
        chk({tag, "_max_idx"}, max_idx, 0);
`endif
    endtask

    initial begin
        bit   s;
        int   n;

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        samp = '{8'h10, 8'h80, 8'h05, 8'h7F};
        start_window(8'd4, 1'b0);
        feed(0, 4);
        check_done(1'b0, 0);
        chk("unsigned_min_const", min_val, 8'h05);
        chk("unsigned_max_const", max_val, 8'h80);

        start_window(8'd4, 1'b1);
        feed(0, 4);
        check_done(1'b1, 0);
        chk("signed_min_const", min_val, 8'h80);
        chk("signed_max_const", max_val, 8'h7F);

        samp = '{8'h33, 8'hC4};
        start_window(8'd2, 1'b0);
        feed(0, 2);
        check_done(1'b0, 5);

        samp = '{8'h20, 8'h20, 8'h20};
        start_window(8'd3, 1'b1);
        feed(3, 3);
        check_done(1'b1, 0);

        samp = '{8'h44, 8'h99, 8'h01, 8'h02};
        start_window(8'd4, 1'b0);
        feed(0, 2);
        #1 rst = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        samp = '{8'hAA};
        start_window(8'd1, 1'b0);
        feed(0, 1);
        check_done(1'b0, 0);

        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_busy", busy, 0);
        chk("len0_in_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_ignores_in_count", count, 1);
        chk("idle_ignores_in_min", min_val, 8'hAA);

        samp.delete();
        for (int i = 0; i < 255; i++) samp.push_back(W'(i));
        start_window(8'd255, 1'b0);
        feed(0, 255);
        check_done(1'b0, 0);
        chk("len255_count_const", count, 255);

        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(12, 1);
            s = 1'($urandom);
            samp.delete();
            for (int i = 0; i < n; i++) samp.push_back(W'($urandom));
            start_window(8'(n), s);
            feed(2, n);
            check_done(s, $urandom_range(3, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
